// File: rtl/lcd_rgb_capture.sv
// lcd_rgb_capture
//   Receive side of the parallel RGB LCD bus. It samples DE/HSYNC/VSYNC/RGB on
//   the pixel clock, packs active pixels to RGB565 and pushes them into the
//   16-bit pixel FIFO so the display path can be checked in loop-back. It also
//   reports frame start, the completed-line count and sticky overflow and
//   line-length errors.
// Ports
//   CLK, RST           pixel clock; synchronous active-high reset
//   LCD_DE             data enable, delimits lines
//   LCD_HSYNC          sampled only, no framing role
//   LCD_VSYNC          frame sync, polarity set by SYNC_ACTIVE_LOW
//   VGA_R/G/B          24-bit pixel
//   FIFO_Full          FIFO cannot take a write this cycle
//   FIFO_WE/FIFO_Data  FIFO write port, data = {R[7:3],G[7:2],B[7:3]}
//   FRAME_START        1-cycle pulse on VSYNC assertion
//   LINE_CNT           completed active lines this frame (saturates at V_ACTIVE)
//   OVF_CLR            clears OVERFLOW and LEN_ERR
//   OVERFLOW           sticky: pixel dropped because FIFO was full
//   LEN_ERR            sticky: a line did not have exactly H_ACTIVE pixels
module lcd_rgb_capture #(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LCD_DE,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        FIFO_Full,
  output logic        FIFO_WE,
  output logic [15:0] FIFO_Data,
  output logic        FRAME_START,
  output logic [15:0] LINE_CNT,
  input  logic        OVF_CLR,
  output logic        OVERFLOW,
  output logic        LEN_ERR
);

  typedef enum logic [1:0] {WAIT_VS, WAIT_DE, LINE} state_e;

  localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [15:0] H_LEN     = 16'(H_ACTIVE);
  localparam logic [15:0] V_LEN     = 16'(V_ACTIVE);

  // stage 1: raw bus sample
  logic       de_q, hs_q, vs_q, vs_prev_q, full_q;
  logic [7:0] r_q, g_q, b_q;

  // stage 2 / control state
  state_e      state_q;
  logic [15:0] pix_cnt_q, line_cnt_q, data_q;
  logic        we_q, fs_q, ovf_q, len_q;

  // HSYNC is captured with the rest of the bus but has no framing role
  logic unused_hs;
  assign unused_hs = hs_q;

  logic        vs_assert, take_pix, in_range, wr, ovf_set, line_end, len_set;
  logic [15:0] pix_idx, pix_cnt_inc, line_cnt_inc;

  // VSYNC edge is detected between the stage-1 sample and the one before it
  assign vs_assert = (vs_q != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);

  // Frame sync wins over any pixel/line-end activity in the same cycle
  assign take_pix = de_q && !vs_assert && (state_q == WAIT_DE || state_q == LINE);
  assign pix_idx  = (state_q == LINE) ? pix_cnt_q : 16'd0;
  assign in_range = pix_idx < H_LEN;
  assign wr       = take_pix && in_range && !full_q;
  // Over-long pixels are not an overflow; LEN_ERR reports them at line end
  assign ovf_set  = take_pix && in_range && full_q;
  assign line_end = (state_q == LINE) && !de_q && !vs_assert;
  assign len_set  = (vs_assert && state_q == LINE) ||
                    (line_end && pix_cnt_q != H_LEN);

  assign pix_cnt_inc  = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
  assign line_cnt_inc = (line_cnt_q == V_LEN) ? line_cnt_q : line_cnt_q + 16'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      de_q       <= 1'b0;
      hs_q       <= SYNC_IDLE;
      vs_q       <= SYNC_IDLE;
      vs_prev_q  <= SYNC_IDLE;
      full_q     <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      state_q    <= WAIT_VS;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      fs_q       <= 1'b0;
      ovf_q      <= 1'b0;
      len_q      <= 1'b0;
    end else begin
      de_q      <= LCD_DE;
      hs_q      <= LCD_HSYNC;
      vs_q      <= LCD_VSYNC;
      vs_prev_q <= vs_q;
      full_q    <= FIFO_Full;
      r_q       <= VGA_R;
      g_q       <= VGA_G;
      b_q       <= VGA_B;

      we_q <= wr;
      if (wr) data_q <= {r_q[7:3], g_q[7:2], b_q[7:3]};
      fs_q <= vs_assert;

      // a set event in the clearing cycle keeps the flag
      ovf_q <= ovf_set || (ovf_q && !OVF_CLR);
      len_q <= len_set || (len_q && !OVF_CLR);

      if (vs_assert) begin
        line_cnt_q <= '0;
        pix_cnt_q  <= '0;
        state_q    <= WAIT_DE;
      end else begin
        unique case (state_q)
          WAIT_VS: ;
          WAIT_DE: begin
            if (de_q) begin
              state_q   <= LINE;
              pix_cnt_q <= 16'd1;
            end
          end
          LINE: begin
            if (de_q) begin
              pix_cnt_q <= pix_cnt_inc;
            end else begin
              line_cnt_q <= line_cnt_inc;
              pix_cnt_q  <= '0;
              state_q    <= (line_cnt_inc == V_LEN) ? WAIT_VS : WAIT_DE;
            end
          end
          default: state_q <= WAIT_VS;
        endcase
      end
    end
  end

  assign FIFO_WE     = we_q;
  assign FIFO_Data   = data_q;
  assign FRAME_START = fs_q;
  assign LINE_CNT    = line_cnt_q;
  assign OVERFLOW    = ovf_q;
  assign LEN_ERR     = len_q;

endmodule

// File: tb/tb_lcd_rgb_capture.sv
module tb_lcd_rgb_capture;
  logic        CLK = 1'b0;
  logic        RST, LCD_DE, LCD_HSYNC, LCD_VSYNC, FIFO_Full, OVF_CLR;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        we1, fs1, ovf1, len1, we2, fs2, ovf2, len2;
  logic [15:0] data1, lc1, data2, lc2;

  lcd_rgb_capture dut (
    .CLK(CLK), .RST(RST), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .FIFO_Full(FIFO_Full),
    .FIFO_WE(we1), .FIFO_Data(data1), .FRAME_START(fs1), .LINE_CNT(lc1),
    .OVF_CLR(OVF_CLR), .OVERFLOW(ovf1), .LEN_ERR(len1));

  // short-frame instance, same stimulus
  lcd_rgb_capture #(.V_ACTIVE(4)) dut4 (
    .CLK(CLK), .RST(RST), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .FIFO_Full(FIFO_Full),
    .FIFO_WE(we2), .FIFO_Data(data2), .FRAME_START(fs2), .LINE_CNT(lc2),
    .OVF_CLR(OVF_CLR), .OVERFLOW(ovf2), .LEN_ERR(len2));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int          wcnt = 0, wcnt2 = 0, dbad = 0, fscnt = 0, first_we = -1;
  logic [15:0] exp_data = 16'h0;
  always @(negedge CLK) begin
    if (we1) begin
      wcnt++;
      if (data1 !== exp_data) dbad++;
      if (first_we < 0) first_we = cyc;
    end
    if (we2) wcnt2++;
    if (fs1) fscnt++;
  end

  int total = 0, bad = 0;
  int line_start = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(2); RST = 1'b0; tick(2);
  endtask

  task automatic vsync_pulse();
    LCD_VSYNC = 1'b0; tick(2); LCD_VSYNC = 1'b1; tick(5);
  endtask

  task automatic set_pix(input logic [7:0] r, g, b, input logic [15:0] e);
    VGA_R = r; VGA_G = g; VGA_B = b; exp_data = e;
  endtask

  // n DE cycles; FIFO_Full high for pixel indices flo..fhi; optional idle gap
  task automatic drive_de(input int n, input int flo, input int fhi, input bit gap);
    for (int i = 0; i < n; i++) begin
      LCD_DE = 1'b1;
      FIFO_Full = (i >= flo && i <= fhi);
      if (i == 0) line_start = cyc;
      tick(1);
    end
    FIFO_Full = 1'b0;
    if (gap) begin
      LCD_DE = 1'b0;
      tick(10);
    end
  endtask

  initial begin
    int w0, w20, d0, f0;
    RST = 1'b1; LCD_DE = 1'b0; LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b1;
    FIFO_Full = 1'b0; OVF_CLR = 1'b0; VGA_R = '0; VGA_G = '0; VGA_B = '0;
    tick(1);

    // 1: two good lines
    do_reset();
    chk("rst_outs", {15'd0, we1, fs1, ovf1, len1, lc1, data1}, 32'd0);
    w0 = wcnt; d0 = dbad; f0 = fscnt;
    set_pix(8'hF8, 8'hFC, 8'hF8, 16'hFFFF);
    vsync_pulse();
    chk("t1_fs", fscnt - f0, 1);
    drive_de(800, -1, -1, 1'b1);
    chk("t1_lat", first_we - line_start, 2);
    drive_de(800, -1, -1, 1'b1);
    chk("t1_writes", wcnt - w0, 1600);
    chk("t1_lcnt", lc1, 2);
    chk("t1_len", len1, 0);
    chk("t1_data", dbad - d0, 0);

    // 2: short then long line
    do_reset();
    w0 = wcnt; d0 = dbad;
    set_pix(8'hA5, 8'h3C, 8'h96, 16'hA1F2);
    vsync_pulse();
    drive_de(799, -1, -1, 1'b1);
    chk("t2_len1", len1, 1);
    chk("t2_lcnt1", lc1, 1);
    drive_de(801, -1, -1, 1'b1);
    chk("t2_writes", wcnt - w0, 1599);
    chk("t2_lcnt2", lc1, 2);
    chk("t2_data", dbad - d0, 0);

    // 3: FIFO full for pixels 10..14
    do_reset();
    w0 = wcnt; d0 = dbad;
    set_pix(8'h12, 8'h34, 8'h56, 16'h11AA);
    vsync_pulse();
    drive_de(800, 10, 14, 1'b1);
    chk("t3_writes", wcnt - w0, 795);
    chk("t3_ovf", ovf1, 1);
    chk("t3_len", len1, 0);
    chk("t3_hold", data1, 16'h11AA);
    chk("t3_data", dbad - d0, 0);
    OVF_CLR = 1'b1; tick(1); OVF_CLR = 1'b0; tick(1);
    chk("t3_clr", ovf1, 0);

    // 4: six lines into a 4-line frame
    do_reset();
    w20 = wcnt2;
    set_pix(8'hF8, 8'hFC, 8'hF8, 16'hFFFF);
    vsync_pulse();
    for (int l = 0; l < 6; l++) drive_de(800, -1, -1, 1'b1);
    chk("t4_writes4", wcnt2 - w20, 3200);
    chk("t4_lcnt4", lc2, 4);
    chk("t4_lcnt_full", lc1, 6);

    // 5: VSYNC in the middle of a line
    do_reset();
    w0 = wcnt;
    vsync_pulse();
    drive_de(800, -1, -1, 1'b1);
    chk("t5_lcnt_pre", lc1, 1);
    drive_de(400, -1, -1, 1'b0);
    f0 = fscnt;
    LCD_DE = 1'b0; LCD_VSYNC = 1'b0; tick(2); LCD_VSYNC = 1'b1; tick(5);
    chk("t5_fs", fscnt - f0, 1);
    chk("t5_len", len1, 1);
    chk("t5_lcnt0", lc1, 0);
    drive_de(800, -1, -1, 1'b1);
    chk("t5_lcnt1", lc1, 1);
    chk("t5_writes", wcnt - w0, 2000);

    // 6: DE before any VSYNC, then reset mid-line
    do_reset();
    w0 = wcnt;
    drive_de(800, -1, -1, 1'b1);
    chk("t6_novs", wcnt - w0, 0);
    vsync_pulse();
    drive_de(800, -1, -1, 1'b1);
    drive_de(10, -1, -1, 1'b1);
    chk("t6_len_pre", len1, 1);
    drive_de(400, -1, -1, 1'b0);
    chk("t6_we_pre", we1, 1);
    RST = 1'b1; tick(1);
    chk("t6_rst_outs", {15'd0, we1, fs1, ovf1, len1, lc1, data1}, 32'd0);
    RST = 1'b0;
    w0 = wcnt;
    drive_de(800, -1, -1, 1'b1);
    chk("t6_waitvs", wcnt - w0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
